// File: rtl/ascon_share_serdes.sv
// Serial-to-parallel share loader and parallel-to-serial result unloader for masked Ascon operands.
// Loads NS shares MSB-first, starts the core, captures its result (dummy on auth failure) and streams it LSB-first.
module ascon_share_serdes #(
  parameter int NS      = 5,
  parameter int LANE    = 1,
  parameter int IN_LEN  = 128,
  parameter int OUT_LEN = 128
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 abort,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [NS*LANE-1:0]   in_data,
  output logic                 load_done,
  output logic [NS*IN_LEN-1:0] par_out,
  input  logic                 core_go,
  output logic                 core_start,
  input  logic                 res_valid,
  output logic                 res_ready,
  input  logic [OUT_LEN-1:0]   res_data,
  input  logic                 res_auth,
  input  logic [OUT_LEN-1:0]   res_dummy,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [LANE-1:0]      out_data,
  output logic                 out_last,
  output logic                 out_auth,
  output logic                 busy
);

  localparam int IN_BEATS  = (IN_LEN + LANE - 1) / LANE;
  localparam int OUT_BEATS = (OUT_LEN + LANE - 1) / LANE;
  localparam int OUT_W     = OUT_BEATS * LANE;
  localparam int ICW       = $clog2(IN_BEATS + 1);
  localparam int OCW       = $clog2(OUT_BEATS + 1);

  localparam logic [ICW-1:0] IN_FULL  = ICW'(IN_BEATS);
  localparam logic [ICW-1:0] IN_LAST  = ICW'(IN_BEATS - 1);
  localparam logic [OCW-1:0] OUT_LAST = OCW'(OUT_BEATS - 1);

  typedef enum logic [1:0] {
    LOAD,
    READY,
    WAIT_CORE,
    UNLOAD
  } state_e;

  state_e              state_q, state_d;
  logic [ICW-1:0]      icnt_q;
  logic [OCW-1:0]      ocnt_q;
  logic [IN_LEN-1:0]   sh_q [NS];
  logic [OUT_LEN-1:0]  res_q;
  logic                auth_q;
  logic                core_start_q;

  logic                in_fire;
  logic                res_fire;
  logic                out_fire;
  logic                in_last;
  logic                out_last_beat;
  logic [OUT_W-1:0]    res_shift;

  assign in_fire       = in_valid  && (state_q == LOAD);
  assign res_fire      = res_valid && (state_q == WAIT_CORE);
  assign out_fire      = out_ready && (state_q == UNLOAD);
  assign in_last       = (icnt_q == IN_LAST);
  assign out_last_beat = (ocnt_q == OUT_LAST);

  // State register
  always_ff @(posedge clk) begin
    if (rst || abort) begin
      state_q <= LOAD;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      LOAD:      if (in_fire && in_last)        state_d = READY;
      READY:     if (core_go)                   state_d = WAIT_CORE;
      WAIT_CORE: if (res_fire)                  state_d = UNLOAD;
      UNLOAD:    if (out_fire && out_last_beat) state_d = LOAD;
      default:                                  state_d = LOAD;
    endcase
  end

  // Share registers hold only IN_LEN bits: padding from the first beat shifts out naturally.
  always_ff @(posedge clk) begin
    if (rst || abort) begin
      for (int unsigned s = 0; s < NS; s++) sh_q[s] <= '0;
      icnt_q       <= '0;
      ocnt_q       <= '0;
      res_q        <= '0;
      auth_q       <= 1'b0;
      core_start_q <= 1'b0;
    end else begin
      core_start_q <= (state_q == READY) && core_go;

      if (in_fire) begin
        for (int unsigned s = 0; s < NS; s++) begin
          sh_q[s] <= (sh_q[s] << LANE) | IN_LEN'(in_data[s*LANE +: LANE]);
        end
        if (icnt_q != IN_FULL) icnt_q <= icnt_q + 1'b1;
      end

      if (res_fire) begin
        res_q  <= res_auth ? res_data : res_dummy;
        auth_q <= res_auth;
      end

      if (out_fire) begin
        if (out_last_beat) begin
          for (int unsigned s = 0; s < NS; s++) sh_q[s] <= '0;
          icnt_q <= '0;
          ocnt_q <= '0;
          res_q  <= '0;
          auth_q <= 1'b0;
        end else if (ocnt_q != OUT_LAST) begin
          ocnt_q <= ocnt_q + 1'b1;
        end
      end
    end
  end

  for (genvar g = 0; g < NS; g++) begin : g_par
    assign par_out[g*IN_LEN +: IN_LEN] = sh_q[g];
  end

  // Zero-extension to whole beats drives positions >= OUT_LEN as 0.
  assign res_shift = OUT_W'(res_q) >> (int'(ocnt_q) * LANE);

  // Output logic
  always_comb begin
    in_ready   = (state_q == LOAD);
    load_done  = (state_q != LOAD);
    busy       = (state_q != LOAD);
    res_ready  = (state_q == WAIT_CORE);
    out_valid  = (state_q == UNLOAD);
    out_last   = (state_q == UNLOAD) && out_last_beat;
    out_data   = (state_q == UNLOAD) ? res_shift[LANE-1:0] : '0;
    out_auth   = auth_q;
    core_start = core_start_q;
  end

endmodule

// File: tb/tb_ascon_share_serdes.sv
// Directed and randomized self-checking bench for ascon_share_serdes (NS=2, LANE=4, IN_LEN=OUT_LEN=10).
module tb_ascon_share_serdes;

  localparam int NS      = 2;
  localparam int LANE    = 4;
  localparam int IN_LEN  = 10;
  localparam int OUT_LEN = 10;

  logic                 clk = 1'b0;
  logic                 rst, abort, in_valid, in_ready, load_done;
  logic [NS*LANE-1:0]   in_data;
  logic [NS*IN_LEN-1:0] par_out;
  logic                 core_go, core_start, res_valid, res_ready, res_auth;
  logic [OUT_LEN-1:0]   res_data, res_dummy;
  logic                 out_valid, out_ready, out_last, out_auth, busy;
  logic [LANE-1:0]      out_data;

  int n_assert = 0;
  int n_fail   = 0;
  logic [IN_LEN-1:0] exp_par0, exp_par1;

  ascon_share_serdes #(.NS(NS), .LANE(LANE), .IN_LEN(IN_LEN), .OUT_LEN(OUT_LEN)) dut (
    .clk(clk), .rst(rst), .abort(abort),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .load_done(load_done), .par_out(par_out),
    .core_go(core_go), .core_start(core_start),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_auth(res_auth), .res_dummy(res_dummy),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .out_auth(out_auth), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    chk({tag, ".in_ready"},   in_ready,   1);
    chk({tag, ".load_done"},  load_done,  0);
    chk({tag, ".busy"},       busy,       0);
    chk({tag, ".out_valid"},  out_valid,  0);
    chk({tag, ".out_data"},   out_data,   0);
    chk({tag, ".out_auth"},   out_auth,   0);
    chk({tag, ".res_ready"},  res_ready,  0);
    chk({tag, ".core_start"}, core_start, 0);
    chk({tag, ".par_out"},    par_out,    0);
  endtask

  // Shares are given as 12-bit beat concatenations (MSB-first); operand = low IN_LEN bits.
  task automatic load_op(input string tag, input logic [11:0] s0, input logic [11:0] s1,
                         input int gap_pct, input int nbeats);
    logic [11:0] t0, t1;
    exp_par0 = s0[IN_LEN-1:0];
    exp_par1 = s1[IN_LEN-1:0];
    for (int i = 0; i < nbeats; i++) begin
      for (int g = 0; g < 4 && $urandom_range(99) < gap_pct; g++) begin
        in_valid  = 1'b0;
        in_data   = NS*LANE'($urandom);
        res_valid = 1'($urandom);
        @(negedge clk);
        chk({tag, ".gap_ready"}, in_ready, 1);
      end
      chk({tag, ".beat_ready"}, in_ready,  1);
      chk({tag, ".beat_done"},  load_done, 0);
      t0 = s0 >> (4 * (2 - i));
      t1 = s1 >> (4 * (2 - i));
      in_valid  = 1'b1;
      res_valid = 1'b0;
      in_data   = {t1[3:0], t0[3:0]};
      @(negedge clk);
    end
    in_valid  = 1'b0;
    res_valid = 1'b0;
    if (nbeats == 3) begin
      chk({tag, ".load_done"}, load_done, 1);
      chk({tag, ".in_ready"},  in_ready,  0);
      chk({tag, ".busy"},      busy,      1);
      chk({tag, ".par_out"},   par_out,   {exp_par1, exp_par0});
    end
  endtask

  task automatic go_core(input string tag, input int idle_cycles);
    for (int i = 0; i < idle_cycles; i++) begin
      @(negedge clk);
      chk({tag, ".ready_idle_start"}, core_start, 0);
      chk({tag, ".ready_idle_done"},  load_done,  1);
      chk({tag, ".ready_idle_rr"},    res_ready,  0);
    end
    core_go = 1'b1;
    @(negedge clk);
    chk({tag, ".start_pulse"}, core_start, 1);
    chk({tag, ".res_ready"},   res_ready,  1);
    @(negedge clk);
    core_go = 1'b0;
    chk({tag, ".start_single"}, core_start, 0);
    chk({tag, ".wait_rr"},      res_ready,  1);
    chk({tag, ".wait_par"},     par_out,    {exp_par1, exp_par0});
  endtask

  task automatic unload(input string tag, input logic [9:0] rd, input logic auth,
                        input logic [9:0] dm, input logic [15:0] pat,
                        input bit no_real, input int rst_at);
    logic [9:0]  sel;
    logic [11:0] t;
    logic [11:0] r;
    int b   = 0;
    int cyc = 0;
    sel       = auth ? rd : dm;
    res_valid = 1'b1;
    res_data  = rd;
    res_auth  = auth;
    res_dummy = dm;
    @(negedge clk);
    res_valid = 1'b0;
    res_data  = OUT_LEN'($urandom);
    res_dummy = OUT_LEN'($urandom);
    res_auth  = 1'($urandom);
    chk({tag, ".rr_drop"}, res_ready, 0);
    while (b < 3 && cyc < 40) begin
      t = {2'b00, sel} >> (4 * b);
      r = {2'b00, rd}  >> (4 * b);
      chk({tag, ".out_valid"}, out_valid, 1);
      chk({tag, ".out_data"},  out_data,  t[3:0]);
      chk({tag, ".out_last"},  out_last,  (b == 2));
      chk({tag, ".out_auth"},  out_auth,  auth);
      chk({tag, ".held_par"},  par_out,   {exp_par1, exp_par0});
      chk({tag, ".held_done"}, load_done, 1);
      if (no_real) chk({tag, ".no_real"}, (out_data === r[3:0]), 0);
      if (b == rst_at) begin
        rst       = 1'b1;
        out_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        return;
      end
      out_ready = (cyc < 16) ? pat[cyc] : 1'b1;
      in_valid  = (b < 2) ? 1'($urandom) : 1'b0;
      in_data   = NS*LANE'($urandom);
      @(negedge clk);
      if (out_ready) b++;
      cyc++;
    end
    out_ready = 1'b0;
    in_valid  = 1'b0;
    chk({tag, ".beats"}, b, 3);
    check_idle({tag, ".after"});
  endtask

  initial begin
    rst = 1'b1; abort = 1'b0; in_valid = 1'b0; in_data = '0; core_go = 1'b0;
    res_valid = 1'b0; res_data = '0; res_auth = 1'b0; res_dummy = '0; out_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_idle("reset");

    core_go = 1'b1;
    @(negedge clk);
    core_go = 1'b0;
    chk("go_in_load.start", core_start, 0);
    chk("go_in_load.busy",  busy,       0);

    load_op("load_dir", 12'hF5A, 12'h03C, 0, 3);
    chk("load_dir.share0", par_out[9:0],   10'h35A);
    chk("load_dir.share1", par_out[19:10], 10'h03C);
    go_core("go_dir", 0);
    unload("unload_auth", 10'h2C7, 1'b1, 10'h155, 16'hFFFF, 1'b0, -1);

    load_op("load_b", 12'h123, 12'hABC, 0, 3);
    go_core("go_b", 1);
    unload("unload_dummy", 10'h2C7, 1'b0, 10'h155, 16'hFFFF, 1'b1, -1);

    load_op("load_c", 12'h9E1, 12'h47D, 20, 3);
    go_core("go_c", 0);
    unload("unload_stall", 10'h3A5, 1'b1, 10'h0F0, 16'hFFF9, 1'b0, -1);

    load_op("load_abort", 12'hFFF, 12'hFFF, 0, 2);
    abort    = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'hFF;
    @(negedge clk);
    abort    = 1'b0;
    in_valid = 1'b0;
    check_idle("abort");
    load_op("reload_abort", 12'h5A5, 12'h0C3, 0, 3);
    go_core("go_abort", 0);
    unload("unload_abort", 10'h1E4, 1'b1, 10'h2B1, 16'hFFFF, 1'b0, -1);

    load_op("load_rst", 12'h777, 12'h888, 0, 3);
    go_core("go_rst", 0);
    unload("unload_rst", 10'h2C7, 1'b1, 10'h155, 16'hFFFF, 1'b0, 1);
    check_idle("rst_unload");
    chk("rst_unload.no_start", core_start, 0);
    load_op("reload_rst", 12'h246, 12'h9BD, 0, 3);
    go_core("go_rst2", 0);
    unload("unload_rst2", 10'h0A3, 1'b0, 10'h35C, 16'hFFFF, 1'b0, -1);

    for (int k = 0; k < 25; k++) begin
      load_op("rnd_load", 12'($urandom), 12'($urandom), 30, 3);
      go_core("rnd_go", int'($urandom_range(2)));
      unload("rnd_unload", 10'($urandom), 1'($urandom), 10'($urandom),
             16'($urandom), 1'b0, -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
